// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one 128-bit memory port between I-side and D-side requesters
// D side has priority; the I side wins once it has watched STARVE_MAX consecutive D grants.
module mem_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          starve_q, starve_d;
    logic                d_req;
    logic                force_i;

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_d    = starve_q;
        d_req       = d_read | d_write;
        force_i     = i_read && (starve_q == STARVE_LIM);

        case (state_q)
            IDLE: begin
                if (!i_read) begin
                    starve_d = '0;
                end
                if (d_req && !force_i) begin
                    // Write wins when a misbehaving D side raises both strobes.
                    state_d     = GNT_D;
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_read && starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_read) begin
                    state_d     = GNT_I;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = i_addr;
                    starve_d    = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            starve_q    <= starve_d;
        end
    end

    // Completion is signalled in the same cycle as mem_ready; read data is a straight pass-through.
    assign i_ready   = (state_q == GNT_I) && mem_ready;
    assign d_ready   = (state_q == GNT_D) && mem_ready;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic          mem_auto = 1'b0;
    int            mem_lat = 3;
    logic [AW-1:0] cap_addr = '0;
    logic          cap_wr = 1'b0;
    logic [DW-1:0] cap_wdata = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        if (a == 28'h0000040) return {16{8'hA5}};
        return {4{4'h5, a}};
    endfunction

    function automatic exp_t mk(input logic is_d, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd;
        return e;
    endfunction

    // Memory model: captures an issued command, checks it holds, answers after mem_lat cycles.
    initial begin : responder
        int lat_cnt;
        lat_cnt = -1;
        forever begin
            @(negedge clk);
            if (!mem_auto) begin
                lat_cnt = -1;
                continue;
            end
            mem_ready = 1'b0;
            if (lat_cnt < 0) begin
                if (mem_read || mem_write) begin
                    cap_addr  = mem_addr;
                    cap_wr    = mem_write;
                    cap_wdata = mem_wdata;
                    lat_cnt   = mem_lat;
                end
            end else begin
                check("hold_addr", mem_addr, cap_addr);
                check("hold_cmd", {mem_read, mem_write}, {~cap_wr, cap_wr});
                check("hold_wdata", mem_wdata, cap_wdata);
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = cap_wr ? '0 : pat(cap_addr);
                    lat_cnt   = -1;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ready: got i=%0b d=%0b want none", i_ready, d_ready);
                end else begin
                    e = exp_q.pop_front();
                    check("ready_side", {i_ready, d_ready}, e.is_d ? 2'b01 : 2'b10);
                    check("issued_addr", cap_addr, e.addr);
                    check("issued_cmd", cap_wr, e.wr);
                    if (e.wr) check("issued_wdata", cap_wdata, e.wdata);
                    else check("rdata", e.is_d ? d_rdata : i_rdata, pat(e.addr));
                end
            end
        end
    end

    task automatic i_txn(input logic [AW-1:0] a);
        int n;
        n = 0;
        @(negedge clk);
        i_read = 1'b1; i_addr = a;
        do begin @(negedge clk); #1; n++; end while (!i_ready && n < 200);
        if (!i_ready) begin total++; bad++; $display("FAIL i_timeout: got no i_ready want i_ready"); end
        i_read = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic both, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        d_read = ~wr | both; d_write = wr; d_addr = a; d_wdata = wd;
        do begin @(negedge clk); #1; n++; end while (!d_ready && n < 200);
        if (!d_ready) begin total++; bad++; $display("FAIL d_timeout: got no d_ready want d_ready"); end
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_i_ready"}, i_ready, 0);
        check({tag, "_d_ready"}, d_ready, 0);
    endtask

    initial begin : stim
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Reset asserted mid GNT_D clears everything at once.
        @(negedge clk);
        d_read = 1'b1; d_addr = 28'h0ABCDEF; d_wdata = {4{32'h0BADF00D}};
        @(negedge clk); #1;
        check("pre_reset_mem_read", mem_read, 1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        d_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_reset_idle", mem_read, 0);

        // Lone I read, 3-cycle memory latency.
        mem_auto = 1'b1; mem_lat = 3;
        exp_q.push_back(mk(0, 0, 28'h0000040, '0));
        fork
            i_txn(28'h0000040);
            begin
                @(negedge clk); @(negedge clk); #2;
                check("issue_latency_read", mem_read, 1);
                check("issue_latency_addr", mem_addr, 28'h0000040);
            end
        join

        // Simultaneous requests: D first, I after TURN.
        exp_q.push_back(mk(1, 0, 28'h0000100, '0));
        exp_q.push_back(mk(0, 0, 28'h0000200, '0));
        fork
            i_txn(28'h0000200);
            d_txn(0, 0, 28'h0000100, '0);
        join

        // Starvation: four D grants, then I, then D again.
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(1, 1, 28'(k + 16), {4{32'(k)}}));
        exp_q.push_back(mk(0, 0, 28'h0000300, '0));
        exp_q.push_back(mk(1, 1, 28'h0000020, {4{32'h5}}));
        fork
            i_txn(28'h0000300);
            for (int k = 0; k < 5; k++) begin
                if (k < 4) d_txn(1, 0, 28'(k + 16), {4{32'(k)}});
                else d_txn(1, 0, 28'h0000020, {4{32'h5}});
            end
        join

        // Write held stable over a long grant; request dropped mid-grant still completes.
        mem_lat = 5;
        exp_q.push_back(mk(1, 1, 28'h1234567, {4{32'hDEADBEEF}}));
        @(negedge clk);
        d_write = 1'b1; d_addr = 28'h1234567; d_wdata = {4{32'hDEADBEEF}};
        @(negedge clk); @(negedge clk); #1;
        check("write_strobe", {mem_read, mem_write}, 2'b01);
        d_write = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (8) @(negedge clk);

        // Read and write raised together: write goes out.
        mem_lat = 2;
        exp_q.push_back(mk(1, 1, 28'h0000777, {4{32'hCAFEF00D}}));
        d_txn(1, 1, 28'h0000777, {4{32'hCAFEF00D}});

        // Spurious mem_ready in IDLE and in TURN.
        @(negedge clk);
        mem_auto = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = {4{32'h11112222}};
        #1;
        check("spur_idle_i_ready", i_ready, 0);
        check("spur_idle_d_ready", d_ready, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check("spur_idle_no_issue", {mem_read, mem_write}, 0);
        exp_q.push_back(mk(0, 0, 28'h0000440, '0));
        i_read = 1'b1; i_addr = 28'h0000440;
        @(negedge clk); #1;
        check("manual_issue", mem_read, 1);
        cap_addr = mem_addr; cap_wr = mem_write; cap_wdata = mem_wdata;
        mem_ready = 1'b1; mem_rdata = pat(28'h0000440);
        @(negedge clk);
        i_read = 1'b0;
        mem_ready = 1'b1; mem_rdata = {4{32'h33334444}};
        #1;
        check("spur_turn_i_ready", i_ready, 0);
        check("spur_turn_d_ready", d_ready, 0);
        check("spur_turn_no_issue", {mem_read, mem_write}, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check("spur_turn_idle", {mem_read, mem_write}, 0);

        mem_auto = 1'b1; mem_lat = 1;
        exp_q.push_back(mk(0, 0, 28'h0000050, '0));
        i_txn(28'h0000050);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
